// File: rtl/sigmoid_lut_writer.sv
// Loadable 64-entry sigmoid lookup table: sequential write port fills the table,
// then signed Q8.8 operands are mapped onto 0.25-wide bins and read with latency 1.
module sigmoid_lut_writer #(
   parameter int N         = 16,
   parameter int LUT_DEPTH = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_start,
   input  logic         wr_valid,
   input  logic [N-1:0] wr_data,
   output logic         wr_ready,
   output logic         load_done,
   output logic         lut_valid,
   input  logic         rd_en,
   input  logic [N-1:0] rd_in,
   output logic         rd_valid,
   output logic [N-1:0] rd_data
);

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   localparam logic [5:0]         LAST_ADDR = 6'(LUT_DEPTH - 1);
   localparam logic signed [N:0]  IDX_MIN   = '0;
   localparam logic signed [N:0]  IDX_MAX   = (N+1)'(63);
   localparam logic signed [N:0]  IDX_OFF   = (N+1)'(32);

   state_t           state, state_nxt;
   logic [5:0]       addr, addr_nxt;
   logic             wr_en, done_nxt, lut_valid_nxt, rd_accept;
   logic signed [N:0] rd_ext, idx_wide;
   logic [5:0]       rd_idx;
   logic [N-1:0]     mem [LUT_DEPTH];

   // Saturate the biased bin number into the table range.
   function automatic logic [5:0] sat_idx(input logic signed [N:0] v);
      if (v < IDX_MIN)      return 6'd0;
      else if (v > IDX_MAX) return 6'd63;
      else                  return v[5:0];
   endfunction

   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      wr_en         = 1'b0;
      done_nxt      = 1'b0;
      lut_valid_nxt = lut_valid;
      wr_ready      = 1'b0;
      case (state)
         IDLE, READY: begin
            if (load_start) begin
               state_nxt     = LOAD;
               addr_nxt      = '0;
               lut_valid_nxt = 1'b0;
            end
         end
         LOAD: begin
            wr_ready = 1'b1;
            // A restart request wins over a beat arriving in the same cycle.
            if (load_start) begin
               addr_nxt = '0;
            end else if (wr_valid) begin
               wr_en    = 1'b1;
               addr_nxt = addr + 6'd1;
               if (addr == LAST_ADDR) begin
                  state_nxt     = READY;
                  done_nxt      = 1'b1;
                  lut_valid_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         load_done <= 1'b0;
         lut_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         addr      <= addr_nxt;
         load_done <= done_nxt;
         lut_valid <= lut_valid_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wr_data;
   end

   // Lookup index: 64 LSBs per bin in Q8.8, biased so 0.0 lands on entry 32.
   assign rd_ext    = {rd_in[N-1], rd_in};
   assign idx_wide  = (rd_ext >>> 6) + IDX_OFF;
   assign rd_idx    = sat_idx(idx_wide);
   assign rd_accept = (state == READY) && rd_en;

   // Read stage: registered table output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_accept;
         if (rd_accept) rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: tb/tb_sigmoid_lut_writer.sv
// Scoreboard bench for sigmoid_lut_writer: load sequences, index clamping, aborts, reset.
module tb_sigmoid_lut_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start, wr_valid, rd_en;
   logic [15:0] wr_data, rd_in;
   logic        wr_ready, load_done, lut_valid, rd_valid;
   logic [15:0] rd_data;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_mem [64];
   logic [15:0] exp_q [$];

   sigmoid_lut_writer #(.N(16), .LUT_DEPTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_valid(wr_valid),
      .wr_data(wr_data), .wr_ready(wr_ready), .load_done(load_done),
      .lut_valid(lut_valid), .rd_en(rd_en), .rd_in(rd_in),
      .rd_valid(rd_valid), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_idx(input logic [15:0] v);
      int s;
      int t;
      s = int'($signed(v));
      t = (s >>> 6) + 32;
      if (t < 0) t = 0;
      if (t > 63) t = 63;
      return t;
   endfunction

   function automatic logic [15:0] op_for(input int i);
      return 16'((i - 32) * 64);
   endfunction

   task automatic pulse_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load_start = 0; wr_valid = 0; wr_data = '0; rd_en = 0; rd_in = '0;
      step(); step();
      checks++;
      if ({wr_ready, load_done, lut_valid, rd_valid, rd_data} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0", {wr_ready, load_done, lut_valid, rd_valid, rd_data});
      end
      rst_n = 1'b1;
      step(); step(); step();
      checks++;
      if (wr_ready !== 1'b0 || lut_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset wr_ready=%b lut_valid=%b exp 0 0", wr_ready, lut_valid);
      end
   endtask

   task automatic test_read_before_load();
      rd_en = 1'b1; rd_in = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_read rd_valid=%b exp=0", rd_valid);
         end
      end
      pulse_load();
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_wr_ready got=%b exp=1", wr_ready);
      end
      rd_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_read rd_valid=%b exp=0", rd_valid);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_full_load();
      int pulses = 0;
      pulse_load();
      for (int i = 0; i < 64; i++) begin
         wr_valid = 1'b1;
         wr_data  = 16'(i * 4);
         exp_mem[i] = 16'(i * 4);
         step();
         if (load_done === 1'b1) pulses++;
         if (i == 62) begin
            checks++;
            if (lut_valid !== 1'b0) begin
               errors++;
               $display("FAIL lut_valid_early got=%b exp=0", lut_valid);
            end
         end
      end
      wr_valid = 1'b0;
      checks++;
      if (load_done !== 1'b1 || lut_valid !== 1'b1 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_complete done=%b valid=%b ready=%b exp 1 1 0", load_done, lut_valid, wr_ready);
      end
      step();
      if (load_done === 1'b1) pulses++;
      checks++;
      if (pulses != 1 || lut_valid !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse_count got=%0d valid=%b exp 1 1", pulses, lut_valid);
      end
      rd_en = 1'b1; rd_in = 16'h0000;
      exp_q.push_back(16'h0080);
      step();
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q.pop_front()) begin
         errors++;
         $display("FAIL lookup_zero valid=%b data=%h exp 1 0080", rd_valid, rd_data);
      end
      step();
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_idle got=%b exp=0", rd_valid);
      end
   endtask

   task automatic test_clamp_back_to_back();
      logic [15:0] ops [6];
      logic [15:0] e;
      ops = '{16'h8000, 16'hF800, 16'h07C0, 16'h7FFF, 16'h0040, 16'hFFC0};
      for (int k = 0; k <= 6; k++) begin
         if (k < 6) begin
            rd_en = 1'b1; rd_in = ops[k];
            exp_q.push_back(exp_mem[ref_idx(ops[k])]);
         end else begin
            rd_en = 1'b0;
         end
         step();
         if (k < 6) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
               errors++;
               $display("FAIL clamp_read%0d valid=%b data=%h exp 1 %h", k, rd_valid, rd_data, e);
            end
         end
      end
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL clamp_tail rd_valid=%b exp=0", rd_valid);
      end
   endtask

   task automatic test_throttled_load();
      int acc = 0;
      int cyc = 0;
      int pulses = 0;
      logic [15:0] e;
      pulse_load();
      while (acc < 64 && cyc < 2000) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data  = 16'($urandom);
         if (wr_valid && wr_ready) begin
            exp_mem[acc] = wr_data;
            acc++;
         end
         step();
         if (load_done === 1'b1) pulses++;
         cyc++;
      end
      wr_valid = 1'b1; wr_data = 16'hFFFF;
      checks++;
      if (acc != 64) begin
         errors++;
         $display("FAIL throttle_timeout accepted=%0d exp=64", acc);
      end
      checks++;
      if (wr_ready !== 1'b0 || lut_valid !== 1'b1 || pulses != 1) begin
         errors++;
         $display("FAIL throttle_done ready=%b valid=%b pulses=%0d exp 0 1 1", wr_ready, lut_valid, pulses);
      end
      for (int i = 0; i <= 64; i++) begin
         if (i < 64) begin
            rd_en = 1'b1; rd_in = op_for(i);
            exp_q.push_back(exp_mem[i]);
         end else begin
            rd_en = 1'b0;
         end
         step();
         wr_valid = 1'b0;
         if (i < 64) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
               errors++;
               $display("FAIL throttle_entry%0d valid=%b data=%h exp 1 %h", i, rd_valid, rd_data, e);
            end
         end
      end
   endtask

   task automatic test_reload_abort();
      int sel [4];
      logic [15:0] e;
      sel = '{0, 1, 20, 63};
      pulse_load();
      checks++;
      if (lut_valid !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reload_enter valid=%b ready=%b exp 0 1", lut_valid, wr_ready);
      end
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'b1; wr_data = 16'hA000 + 16'(i);
         step();
      end
      load_start = 1'b1; wr_valid = 1'b1; wr_data = 16'hDEAD;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         wr_valid = 1'b1; wr_data = 16'h0100 + 16'(i * 3);
         exp_mem[i] = 16'h0100 + 16'(i * 3);
         step();
         if (i == 62) begin
            checks++;
            if (lut_valid !== 1'b0) begin
               errors++;
               $display("FAIL abort_early_valid got=%b exp=0", lut_valid);
            end
         end
      end
      wr_valid = 1'b0;
      checks++;
      if (load_done !== 1'b1 || lut_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_done done=%b valid=%b exp 1 1", load_done, lut_valid);
      end
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) begin
            rd_en = 1'b1; rd_in = op_for(sel[k]);
            exp_q.push_back(exp_mem[sel[k]]);
         end else begin
            rd_en = 1'b0;
         end
         step();
         if (k < 4) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
               errors++;
               $display("FAIL abort_entry%0d valid=%b data=%h exp 1 %h", sel[k], rd_valid, rd_data, e);
            end
         end
      end
   endtask

   task automatic test_read_during_reload();
      logic [15:0] e;
      rd_en = 1'b1; rd_in = op_for(10); load_start = 1'b1;
      exp_q.push_back(exp_mem[10]);
      step();
      rd_en = 1'b0; load_start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e || wr_ready !== 1'b1 || lut_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_on_reload valid=%b data=%h ready=%b lut=%b exp 1 %h 1 0", rd_valid, rd_data, wr_ready, lut_valid, e);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] e;
      for (int i = 0; i < 40; i++) begin
         wr_valid = 1'b1; wr_data = 16'h5000 + 16'(i);
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_ready, load_done, lut_valid, rd_valid, rd_data} !== 20'd0) begin
         errors++;
         $display("FAIL async_reset got=%h exp=0", {wr_ready, load_done, lut_valid, rd_valid, rd_data});
      end
      wr_valid = 1'b0;
      step();
      rst_n = 1'b1;
      rd_en = 1'b1; rd_in = 16'h0000;
      step(); step();
      checks++;
      if (rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_read valid=%b ready=%b exp 0 0", rd_valid, wr_ready);
      end
      rd_en = 1'b0;
      pulse_load();
      for (int i = 0; i < 64; i++) begin
         wr_valid = 1'b1; wr_data = ~16'(i);
         exp_mem[i] = ~16'(i);
         step();
      end
      wr_valid = 1'b0;
      rd_en = 1'b1; rd_in = op_for(45);
      exp_q.push_back(exp_mem[45]);
      step();
      rd_en = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e || lut_valid !== 1'b1) begin
         errors++;
         $display("FAIL reload_after_reset valid=%b data=%h lut=%b exp 1 %h 1", rd_valid, rd_data, lut_valid, e);
      end
   endtask

   initial begin
      test_reset();
      test_read_before_load();
      test_full_load();
      test_clamp_back_to_back();
      test_throttled_load();
      test_reload_abort();
      test_read_during_reload();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sigmoid_lut_writer.md
SIGMOID_LUT_WRITER -- requirements
Module: sigmoid_lut_writer

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning data width of LUT entries and lookup input (signed Q8.8).
REQ-002 The block SHALL have parameter LUT_DEPTH, default 64, meaning entry count; only 64 is supported.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: single clock, all logic on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port load_start, input, 1: single-cycle request to (re)load all 64 entries.
REQ-007 Port wr_valid, input, 1: the wr_data beat is valid.
REQ-008 Port wr_data, input, N: entry value in Q8.8, written in ascending index order.
REQ-009 Port wr_ready, output, 1: the block accepts a write beat this cycle.
REQ-010 Port load_done, output, 1: one-cycle pulse when the 64th entry has been written.
REQ-011 Port lut_valid, output, 1: level signal; the table is fully loaded and usable.
REQ-012 Port rd_en, input, 1: lookup request.
REQ-013 Port rd_in, input, N: signed Q8.8 lookup operand.
REQ-014 Port rd_valid, output, 1: rd_data is valid this cycle.
REQ-015 Port rd_data, output, N: LUT entry for the rd_in sampled one cycle earlier.

Function
REQ-016 The FSM SHALL have three states: IDLE, LOAD and READY.
REQ-017 From IDLE or READY, load_start SHALL move the FSM to LOAD, clear the write address to 0 and drop lut_valid on the next edge.
REQ-018 In LOAD, wr_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 In LOAD, each cycle with wr_valid=1 and wr_ready=1 SHALL write wr_data to mem[addr] and increment the 6-bit addr.
REQ-020 The write at addr=63 SHALL move the FSM to READY, set lut_valid=1 and pulse load_done=1 for exactly one cycle, all on the same edge.
REQ-021 When load_start is asserted in LOAD, addr SHALL restart at 0 and any concurrent write beat SHALL be discarded; load_start has priority.
REQ-022 When wr_valid=0 in LOAD, the block SHALL hold addr with no timeout.
REQ-023 Lookup index: idx = clamp((rd_in >>> 6) + 32, 0, 63), computed with signed arithmetic at least 11 bits wide; step is 0.25 per entry.
REQ-024 Index mapping examples: -8.0 (0xF800) -> 0; 0.0 -> 32; +7.75 (0x07C0) -> 63; rd_in < -8.0 -> 0; rd_in >= +8.0 -> 63.
REQ-025 In READY, rd_en=1 SHALL give rd_valid=1 and rd_data=mem[idx] on the next cycle (latency 1); one lookup is accepted every cycle, back-to-back.
REQ-026 When not in READY, rd_en SHALL be ignored; rd_valid stays 0 and rd_data holds its last value.
REQ-027 When rd_en and load_start occur in the same READY cycle, the read SHALL be honoured using the old contents, and the FSM still enters LOAD.
REQ-028 rd_valid SHALL be 0 in any cycle not preceded by an accepted rd_en.

Reset
REQ-029 When rst_n=0, the block SHALL immediately force: state=IDLE, addr=0, wr_ready=0, load_done=0, lut_valid=0, rd_valid=0, rd_data=0.
REQ-030 Memory contents SHALL NOT be reset and are undefined until a complete load finishes.
REQ-031 When reset is asserted mid-LOAD, the partial load SHALL be abandoned, and a full 64-beat load SHALL be required afterward.
REQ-032 After rst_n is released, the block SHALL stay in IDLE until load_start.

Verification
REQ-033 Full load: reset, load_start, 64 beats with wr_data=index*4 -> load_done pulses once after beat 64 and lut_valid=1; rd_in=0x0000 -> rd_data=0x0080 one cycle later.
REQ-034 Clamping: after a full load, rd_in=0x8000, 0xF800, 0x07C0, 0x7FFF back-to-back -> rd_data=mem[0], mem[0], mem[63], mem[63] on consecutive cycles, with rd_valid high 4 cycles.
REQ-035 Throttled load: wr_valid toggled randomly -> exactly 64 accepted beats, entries in order, and wr_ready=0 after completion.
REQ-036 Reload abort: load_start at beat 20 with wr_valid=1 -> that beat is dropped, addr restarts at 0, lut_valid=0, and the next 64 beats define the table.
REQ-037 Read before load: rd_en in IDLE and LOAD -> rd_valid stays 0.
REQ-038 Async reset at beat 40 -> all outputs 0 immediately without a clock edge; rd_en is ignored until a new full load completes.
